// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
//   Writeback controller between the execute/memory producers and a 16x16
//   register file. Results are queued in a small FIFO and written through
//   register file port A, which is shared with decode's source-A read.
//   Decode is stalled on RAW hazards against queued results and whenever
//   port A is taken for a write.
//
//   Optional build macro: WB_BYPASS_EN
//     Defined: queued results are forwarded to decode (youngest match wins)
//     and RAW matches no longer stall decode.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   alu_valid/dest/data/ready   ALU result enqueue handshake
//   mem_valid/dest/data/ready   load result enqueue handshake (priority)
//   dec_rd_req, dec_a/b_index   decode read request and source registers
//   dec_stall, dec_a/b_data     decode hold and operand data
//   rf_reg_write, rf_a_index,
//   rf_b_index, rf_write_data   register file control
//   rf_a_data, rf_b_data        register file read data
//   wb_pending                  FIFO occupancy
module regfile_wb_ctrl #(
  parameter int WIDTH      = 16,
  parameter int REG_BITS   = 4,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [REG_BITS-1:0]     alu_dest,
  input  logic [WIDTH-1:0]        alu_data,
  output logic                    alu_ready,
  input  logic                    mem_valid,
  input  logic [REG_BITS-1:0]     mem_dest,
  input  logic [WIDTH-1:0]        mem_data,
  output logic                    mem_ready,
  input  logic                    dec_rd_req,
  input  logic [REG_BITS-1:0]     dec_a_index,
  input  logic [REG_BITS-1:0]     dec_b_index,
  output logic                    dec_stall,
  output logic [WIDTH-1:0]        dec_a_data,
  output logic [WIDTH-1:0]        dec_b_data,
  output logic                    rf_reg_write,
  output logic [REG_BITS-1:0]     rf_a_index,
  output logic [REG_BITS-1:0]     rf_b_index,
  output logic [WIDTH-1:0]        rf_write_data,
  input  logic [WIDTH-1:0]        rf_a_data,
  input  logic [WIDTH-1:0]        rf_b_data,
  output logic [$clog2(DEPTH):0]  wb_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [REG_BITS-1:0] dest_q [DEPTH];
  logic [WIDTH-1:0]    data_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [STV_W-1:0]    starve;

  logic                full, nonempty, raw_match, hazard, write_now;
  logic                enq_fire, push, pop;
  logic [REG_BITS-1:0] enq_dest;
  logic [WIDTH-1:0]    enq_data;
  logic                byp_a_hit, byp_b_hit;
  logic [WIDTH-1:0]    byp_a_data, byp_b_data;

  assign full     = (count == CNT_W'(DEPTH));
  assign nonempty = (count != '0);

  // Walk the queue oldest to youngest so the last hit is the youngest entry.
  always_comb begin
    logic [PTR_W-1:0] idx;
    raw_match  = 1'b0;
    byp_a_hit  = 1'b0;
    byp_b_hit  = 1'b0;
    byp_a_data = '0;
    byp_b_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (dec_a_index != '0 && dest_q[idx] == dec_a_index) begin
          raw_match  = 1'b1;
          byp_a_hit  = 1'b1;
          byp_a_data = data_q[idx];
        end
        if (dec_b_index != '0 && dest_q[idx] == dec_b_index) begin
          raw_match  = 1'b1;
          byp_b_hit  = 1'b1;
          byp_b_data = data_q[idx];
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign hazard     = 1'b0;
  assign dec_a_data = byp_a_hit ? byp_a_data : rf_a_data;
  assign dec_b_data = byp_b_hit ? byp_b_data : rf_b_data;
`else
  assign hazard     = dec_rd_req & raw_match;
  assign dec_a_data = rf_a_data;
  assign dec_b_data = rf_b_data;
`endif

  assign write_now = nonempty &
                     (~dec_rd_req | hazard | full | (starve == STV_W'(STARVE_MAX)));
  assign dec_stall = dec_rd_req & (write_now | hazard);

  assign rf_reg_write  = write_now;
  assign rf_a_index    = write_now ? dest_q[rd_ptr] : dec_a_index;
  assign rf_b_index    = dec_b_index;
  assign rf_write_data = data_q[rd_ptr];

  // Ready is based on the registered count, so a same-cycle pop never frees a slot.
  assign mem_ready = ~full;
  assign alu_ready = ~full & ~mem_valid;
  assign enq_fire  = (mem_valid & mem_ready) | (alu_valid & alu_ready);
  assign enq_dest  = mem_valid ? mem_dest : alu_dest;
  assign enq_data  = mem_valid ? mem_data : alu_data;
  // Writes to register 0 complete the handshake but are dropped.
  assign push      = enq_fire & (enq_dest != '0);
  assign pop       = write_now;

  assign wb_pending = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) begin
        dest_q[wr_ptr] <= enq_dest;
        data_q[wr_ptr] <= enq_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!nonempty || write_now) starve <= '0;
      else                        starve <= starve + 1'b1;
    end
  end

endmodule
